// File: rtl/pix_line_fetch.sv
// Avalon-MM burst reader that fetches a frame one line at a time and streams the
// pixels through a small show-ahead FIFO into the SCANLINE pixel-write port.
module pix_line_fetch #(
  parameter int pWIDTH      = 640,
  parameter int pHEIGHT     = 480,
  parameter int pBURST      = 16,
  parameter int pFIFO_DEPTH = 32
) (
  input  logic                                         iCLK,
  input  logic                                         iRESET,
  input  logic                                         iENABLE,
  input  logic                                         iFRAME_START,
  input  logic [31:0]                                  iFB_BASE,
  output logic [31:0]                                  oAVM_ADDRESS,
  output logic                                         oAVM_READ,
  output logic [$clog2(pBURST):0]                      oAVM_BURSTCOUNT,
  input  logic                                         iAVM_WAITREQUEST,
  input  logic [15:0]                                  iAVM_READDATA,
  input  logic                                         iAVM_READDATAVALID,
  output logic [14:0]                                  oPIX_RGB,
  output logic                                         oPIX_WRITE,
  output logic                                         oPIX_START,
  input  logic                                         iPIX_FULL,
  output logic                                         oBUSY,
  output logic [((pHEIGHT > 1) ? $clog2(pHEIGHT) : 1)-1:0] oLINE,
  output logic [1:0]                                   oDBG_STATE
);

  localparam int cLW  = (pHEIGHT > 1) ? $clog2(pHEIGHT) : 1;
  localparam int cCW  = $clog2(pWIDTH + 1);
  localparam int cFW  = $clog2(pFIFO_DEPTH + 1);
  localparam int cPW  = (pFIFO_DEPTH > 1) ? $clog2(pFIFO_DEPTH) : 1;
  localparam int cBCW = $clog2(pBURST) + 1;

  typedef enum logic [1:0] {
    sIDLE   = 2'd0,
    sLSTART = 2'd1,
    sFETCH  = 2'd2,
    sLEND   = 2'd3
  } fetchState_t;

  // Handshakes: a read burst transfers on a clock edge where oAVM_READ=1 and
  // iAVM_WAITREQUEST=0 (address/read held until then); a beat transfers on every
  // edge with iAVM_READDATAVALID=1 (never throttled); a pixel transfers on every
  // edge with oPIX_WRITE=1, which is only raised while iPIX_FULL=0.

  fetchState_t      state;
  logic [31:0]      lineAddr;
  logic [31:0]      reqAddr;
  logic             avmRead;
  logic             pixStart;
  logic             busy;
  logic [cLW-1:0]   line;
  logic [cCW-1:0]   reqWords;
  logic [cCW-1:0]   wrCount;
  logic [cFW-1:0]   outstanding;

  logic [14:0]      fifoMem [pFIFO_DEPTH];
  logic [cPW-1:0]   rdPtr;
  logic [cPW-1:0]   wrPtr;
  logic [cFW-1:0]   fifoCount;

  logic             avmAccept;
  logic             creditOk;
  logic             pixWrite;
  logic             fifoPush;
  logic             unusedReadMsb;

  function automatic logic [cPW-1:0] nextPtr(input logic [cPW-1:0] p);
    return (p == cPW'(pFIFO_DEPTH - 1)) ? '0 : p + cPW'(1);
  endfunction

  assign avmAccept     = avmRead && !iAVM_WAITREQUEST;
  assign fifoPush      = iAVM_READDATAVALID;
  assign unusedReadMsb = iAVM_READDATA[15];

  // Words already buffered plus words still in flight must leave room for a whole burst.
  assign creditOk = (int'(fifoCount) + int'(outstanding) + pBURST) <= pFIFO_DEPTH;

  assign pixWrite = (state == sFETCH) && (fifoCount != '0) && !iPIX_FULL &&
                    (int'(wrCount) < pWIDTH);

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state    <= sIDLE;
      lineAddr <= '0;
      reqAddr  <= '0;
      avmRead  <= 1'b0;
      pixStart <= 1'b0;
      busy     <= 1'b0;
      line     <= '0;
      reqWords <= '0;
      wrCount  <= '0;
    end else begin
      pixStart <= 1'b0;
      case (state)
        sIDLE: begin
          if (iFRAME_START && iENABLE) begin
            lineAddr <= iFB_BASE;
            line     <= '0;
            busy     <= 1'b1;
            pixStart <= 1'b1;
            state    <= sLSTART;
          end
        end
        sLSTART: begin
          reqWords <= '0;
          wrCount  <= '0;
          reqAddr  <= lineAddr;
          state    <= sFETCH;
        end
        sFETCH: begin
          if (avmAccept) begin
            avmRead  <= 1'b0;
            reqWords <= reqWords + cCW'(pBURST);
            reqAddr  <= reqAddr + 32'(2 * pBURST);
          end else if (!avmRead && (int'(reqWords) < pWIDTH) && creditOk) begin
            avmRead <= 1'b1;
          end
          if (pixWrite) begin
            wrCount <= wrCount + cCW'(1);
            if (wrCount == cCW'(pWIDTH - 1)) begin
              state <= sLEND;
            end
          end
        end
        sLEND: begin
          if (line == cLW'(pHEIGHT - 1)) begin
            busy  <= 1'b0;
            state <= sIDLE;
          end else begin
            line     <= line + cLW'(1);
            lineAddr <= lineAddr + 32'(2 * pWIDTH);
            pixStart <= 1'b1;
            state    <= sLSTART;
          end
        end
        default: state <= sIDLE;
      endcase
    end
  end

  // In-flight word count; a same-cycle acceptance and beat nets to pBURST-1.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      outstanding <= '0;
    end else begin
      case ({avmAccept, fifoPush})
        2'b10:   outstanding <= outstanding + cFW'(pBURST);
        2'b01:   outstanding <= outstanding - cFW'(1);
        2'b11:   outstanding <= outstanding + cFW'(pBURST) - cFW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (fifoPush) begin
        wrPtr <= nextPtr(wrPtr);
      end
      if (pixWrite) begin
        rdPtr <= nextPtr(rdPtr);
      end
      case ({fifoPush, pixWrite})
        2'b10:   fifoCount <= fifoCount + cFW'(1);
        2'b01:   fifoCount <= fifoCount - cFW'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (fifoPush) begin
      fifoMem[wrPtr] <= iAVM_READDATA[14:0];
    end
  end

  assign oAVM_ADDRESS    = reqAddr;
  assign oAVM_READ       = avmRead;
  assign oAVM_BURSTCOUNT = cBCW'(pBURST);
  assign oPIX_RGB        = (fifoCount != '0) ? fifoMem[rdPtr] : 15'd0;
  assign oPIX_WRITE      = pixWrite;
  assign oPIX_START      = pixStart;
  assign oBUSY           = busy;
  assign oLINE           = line;
  assign oDBG_STATE      = state;

endmodule

// File: tb/tb_pix_line_fetch.sv
// Bench for pix_line_fetch: Avalon slave returning address-derived data, a
// randomized SCANLINE sink, and a frame-level reference model of pixels and bursts.
module tb_pix_line_fetch;

  localparam int W  = 32;
  localparam int H  = 2;
  localparam int B  = 8;
  localparam int D  = 16;
  localparam int LW = 1;
  localparam int EW = LW + 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          frame_start = 1'b0;
  logic [31:0]   fb_base = '0;
  logic [31:0]   avm_address;
  logic          avm_read;
  logic [3:0]    avm_burstcount;
  logic          avm_waitrequest = 1'b0;
  logic [15:0]   avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic [14:0]   pix_rgb;
  logic          pix_write;
  logic          pix_start;
  logic          pix_full = 1'b0;
  logic          busy;
  logic [LW-1:0] line;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts, n_writes, n_bursts, n_stall;
  int full_pct  = 0;
  int hold_left = 0;
  bit rnd_wait  = 1'b0;
  bit rnd_gap   = 1'b0;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   exp_burst_q[$];
  logic [31:0]   beat_q[$];

  typedef struct {
    logic [31:0] base;
    int          full_pct;
    int          wait_hold;
    bit          rnd_wait;
    bit          rnd_gap;
    int          exp_starts;
    int          exp_writes;
    int          exp_bursts;
    int          exp_stall;
  } vec_t;

  vec_t vecs[8];

  pix_line_fetch #(.pWIDTH(W), .pHEIGHT(H), .pBURST(B), .pFIFO_DEPTH(D)) dut (
    .iCLK              (clk),
    .iRESET            (rst),
    .iENABLE           (enable),
    .iFRAME_START      (frame_start),
    .iFB_BASE          (fb_base),
    .oAVM_ADDRESS      (avm_address),
    .oAVM_READ         (avm_read),
    .oAVM_BURSTCOUNT   (avm_burstcount),
    .iAVM_WAITREQUEST  (avm_waitrequest),
    .iAVM_READDATA     (avm_readdata),
    .iAVM_READDATAVALID(avm_readdatavalid),
    .oPIX_RGB          (pix_rgb),
    .oPIX_WRITE        (pix_write),
    .oPIX_START        (pix_start),
    .iPIX_FULL         (pix_full),
    .oBUSY             (busy),
    .oLINE             (line),
    .oDBG_STATE        (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic report_fail(input string name, input string detail);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // reference model: linear frame in memory, pixel = address bits [14:0]
  task automatic model_frame(input logic [31:0] base);
    logic [31:0] a;
    for (int l = 0; l < H; l++) begin
      for (int p = 0; p < W; p++) begin
        a = base + 32'(2 * (l * W + p));
        exp_q.push_back({LW'(l), a[14:0]});
      end
    end
    for (int k = 0; k < (W * H) / B; k++) begin
      exp_burst_q.push_back(base + 32'(2 * B * k));
    end
  endtask

  // Avalon slave: queues beats at acceptance, returns address[15:0] per word
  initial begin : avm_slave
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (rst) begin
        beat_q.delete();
      end else if (avm_read && !avm_waitrequest) begin
        for (int i = 0; i < B; i++) beat_q.push_back(avm_address + 32'(2 * i));
      end
      @(posedge clk);
      #1;
      if (rnd_wait) begin
        avm_waitrequest = 1'($urandom_range(0, 1));
      end else if (avm_read && hold_left > 0) begin
        avm_waitrequest = 1'b1;
        hold_left--;
      end else begin
        avm_waitrequest = 1'b0;
      end
      if (beat_q.size() > 0 && (!rnd_gap || $urandom_range(0, 2) != 0)) begin
        a = beat_q.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata = a[15:0];
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata = 16'($urandom);
      end
    end
  end

  // SCANLINE sink backpressure driver
  initial begin : sink_driver
    forever begin
      @(posedge clk);
      #1;
      pix_full = (full_pct >= 100) || (full_pct > 0 && $urandom_range(0, 99) < full_pct);
    end
  end

  // scoreboard / protocol monitor
  initial begin : monitor
    logic          prev_wait;
    logic [31:0]   prev_addr;
    logic [EW-1:0] e;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wait = 1'b0;
        continue;
      end
      if (prev_wait) begin
        check("wait_read_held", avm_read, 1);
        check("wait_addr_held", avm_address, prev_addr);
      end
      prev_wait = avm_read && avm_waitrequest;
      prev_addr = avm_address;
      if (prev_wait) n_stall++;
      if (avm_read && !avm_waitrequest) begin
        n_bursts++;
        if (exp_burst_q.size() == 0) report_fail("extra_burst", $sformatf("addr 0x%0h not expected", avm_address));
        else check("burst_addr", avm_address, exp_burst_q.pop_front());
      end
      if (pix_start) begin
        n_starts++;
        check("start_not_with_write", pix_write, 0);
      end
      if (pix_full) check("no_write_when_full", pix_write, 0);
      if (pix_write) begin
        n_writes++;
        check("write_after_line_start", (n_writes <= n_starts * W) ? 1 : 0, 1);
        if (exp_q.size() == 0) report_fail("extra_pixel", $sformatf("rgb 0x%0h not expected", pix_rgb));
        else begin
          e = exp_q.pop_front();
          check("pixel_line_rgb", {line, pix_rgb}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic clear_counts();
    n_starts = 0;
    n_writes = 0;
    n_bursts = 0;
    n_stall  = 0;
  endtask

  task automatic start_frame(input logic [31:0] base);
    fb_base = base;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    fb_base = $urandom;
    @(negedge clk);
    check("start_pulse", pix_start, 1);
    check("start_busy", busy, 1);
    check("start_no_read_yet", avm_read, 0);
    check("start_line0", line, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) report_fail("frame_timeout", $sformatf("busy still high after %0d cycles", budget));
  endtask

  task automatic frame_end_checks(input int es, input int ew, input int eb);
    check("frame_starts", n_starts, es);
    check("frame_writes", n_writes, ew);
    check("frame_bursts", n_bursts, eb);
    check("frame_pix_left", exp_q.size(), 0);
    check("frame_bursts_left", exp_burst_q.size(), 0);
    check("frame_busy_low", busy, 0);
    check("frame_state_idle", dbg_state, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_avm_read", avm_read, 0);
    check("rst_avm_address", avm_address, 0);
    check("rst_pix_write", pix_write, 0);
    check("rst_pix_start", pix_start, 0);
    check("rst_pix_rgb", pix_rgb, 0);
    check("rst_busy", busy, 0);
    check("rst_line", line, 0);
    check("rst_burstcount", avm_burstcount, B);
    check("rst_state", dbg_state, 0);
  endtask

  initial begin : main
    int n;
    int w0;
    int b0;

    vecs[0] = '{32'h0000_1000, 0,  0, 1'b0, 1'b0, H, W * H, (W * H) / B, 0};
    vecs[1] = '{32'h0000_1000, 50, 0, 1'b0, 1'b0, H, W * H, (W * H) / B, 0};
    vecs[2] = '{32'h0000_1000, 0,  5, 1'b0, 1'b0, H, W * H, (W * H) / B, 5};
    vecs[3] = '{32'hFFFF_FFE0, 0,  0, 1'b0, 1'b1, H, W * H, (W * H) / B, 0};
    vecs[4] = '{32'h0001_7FC0, 30, 0, 1'b1, 1'b1, H, W * H, (W * H) / B, -1};
    for (int i = 5; i < 8; i++) begin
      vecs[i] = '{$urandom & 32'hFFFF_FFFE, int'($urandom_range(0, 80)), 0, 1'b1, 1'b1,
                  H, W * H, (W * H) / B, -1};
    end

    // reset
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;

    // table-driven frames, started back to back as soon as the previous one ends
    for (int i = 0; i < 8; i++) begin
      full_pct  = vecs[i].full_pct;
      rnd_wait  = vecs[i].rnd_wait;
      rnd_gap   = vecs[i].rnd_gap;
      hold_left = vecs[i].wait_hold;
      clear_counts();
      model_frame(vecs[i].base);
      start_frame(vecs[i].base);
      wait_idle(4000);
      frame_end_checks(vecs[i].exp_starts, vecs[i].exp_writes, vecs[i].exp_bursts);
      if (vecs[i].exp_stall >= 0) check("frame_wait_cycles", n_stall, vecs[i].exp_stall);
    end
    rnd_wait = 1'b0;
    rnd_gap  = 1'b0;

    // stalled sink: credits exhaust at FIFO depth
    full_pct = 100;
    clear_counts();
    model_frame(32'h0000_2000);
    start_frame(32'h0000_2000);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("stall_words_requested", n_bursts * B, D);
    check("stall_read_low", avm_read, 0);
    check("stall_no_write", n_writes, 0);
    check("stall_busy", busy, 1);
    @(posedge clk);
    #1;
    full_pct = 0;
    wait_idle(4000);
    frame_end_checks(H, W * H, (W * H) / B);

    // second start pulse mid-frame is ignored
    full_pct = 30;
    clear_counts();
    model_frame(32'h0000_3000);
    start_frame(32'h0000_3000);
    repeat (30) @(posedge clk);
    #1;
    fb_base = 32'h0000_7770;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    wait_idle(4000);
    frame_end_checks(H, W * H, (W * H) / B);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("ignored_no_new_frame", busy, 0);
    check("ignored_starts", n_starts, H);

    // reset during FETCH of line 1
    @(posedge clk);
    #1;
    full_pct = 0;
    clear_counts();
    model_frame(32'h0000_4000);
    start_frame(32'h0000_4000);
    n = 0;
    while (!(line == LW'(1) && n_writes >= W + 8) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("midframe_reached_line1", line, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_burst_q.delete();
    @(negedge clk);
    check_reset_outputs();
    w0 = n_writes;
    b0 = n_bursts;
    // enable low: start requests are not honoured
    @(posedge clk);
    #1;
    enable = 1'b0;
    fb_base = 32'h0000_6000;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    enable = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("post_reset_idle", dbg_state, 0);
    check("post_reset_busy", busy, 0);
    check("post_reset_no_write", n_writes, w0);
    check("post_reset_no_burst", n_bursts, b0);

    // recovery frame after reset
    @(posedge clk);
    #1;
    full_pct = 40;
    clear_counts();
    model_frame(32'h0000_5000);
    start_frame(32'h0000_5000);
    wait_idle(4000);
    frame_end_checks(H, W * H, (W * H) / B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
